// File: rtl/uart_echo_fifo.sv
// Byte FIFO between the UART receiver and transmitter on the echo path, with a
// three-state drain controller that hands one byte at a time to the transmitter.
module uart_echo_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tx_rdy,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_LO,
        S_WAIT_HI
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_rptr;
    logic [ADDR_W:0]     r_count;
    logic                r_tx_en;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_overflow;

    logic                w_full;
    logic                w_empty;
    logic                w_wr_accept;
    logic                w_wr_drop;
    logic                w_pop;

    assign w_full      = (r_count == FULL_COUNT);
    assign w_empty     = (r_count == '0);
    // A write arriving while full is dropped even if a pop frees a slot on the same edge.
    assign w_wr_accept = wr_valid & ~w_full;
    assign w_wr_drop   = wr_valid & w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && tx_rdy) begin
                    w_pop        = 1'b1;
                    w_next_state = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!tx_rdy) begin
                    w_next_state = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_rdy) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: the storage array has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_en <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rptr];
            end
        end
    end

    // A new drop wins over a same-cycle clear so no loss goes unreported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_wr_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign tx_en    = r_tx_en;
    assign tx_data  = r_tx_data;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: directed vector table, fill/overflow
// sequence, randomized traffic against a queue model, and asynchronous reset.
module tb_uart_echo_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              tx_rdy;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              clr_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Transmitter handshake: manual level or a behavioural transmitter.
    logic man_rdy;
    logic model_rdy;
    logic tx_model_on;
    int   tm_phase;
    int   tm_cnt;
    logic [DATA_W-1:0] got_q[$];

    assign tx_rdy = tx_model_on ? model_rdy : man_rdy;

    always #5 clk = ~clk;

    uart_echo_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .tx_rdy   (tx_rdy),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    // Transmitter: after en it may stay ready 0..2 cycles, then busy 1..5 cycles.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            model_rdy <= 1'b1;
            tm_phase  <= 0;
            tm_cnt    <= 0;
        end else if (tx_model_on) begin
            case (tm_phase)
                0: if (tx_en) begin
                    if ($urandom_range(0, 2) == 0) begin
                        model_rdy <= 1'b0;
                        tm_phase  <= 2;
                        tm_cnt    <= int'($urandom_range(1, 5));
                    end else begin
                        tm_phase <= 1;
                        tm_cnt   <= int'($urandom_range(1, 2));
                    end
                end
                1: if (tm_cnt <= 1) begin
                    model_rdy <= 1'b0;
                    tm_phase  <= 2;
                    tm_cnt    <= int'($urandom_range(1, 5));
                end else begin
                    tm_cnt <= tm_cnt - 1;
                end
                default: if (tm_cnt <= 1) begin
                    model_rdy <= 1'b1;
                    tm_phase  <= 0;
                end else begin
                    tm_cnt <= tm_cnt - 1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (tx_en === 1'b1) got_q.push_back(tx_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic              wr;
        logic [DATA_W-1:0] d;
        logic              rdy;
        logic              clr;
        logic [ADDR_W:0]   cnt;
        logic              en;
        logic [DATA_W-1:0] txd;
        logic              ovf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic wr, input logic [7:0] d, input logic rdy, input logic clr,
                       input int cnt, input logic en, input logic [7:0] txd, input logic ovf);
        vec_t v;
        v.wr = wr; v.d = d; v.rdy = rdy; v.clr = clr;
        v.cnt = (ADDR_W + 1)'(cnt); v.en = en; v.txd = txd; v.ovf = ovf;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue-level reference for the randomized phase.
    logic [DATA_W-1:0] m_q[$];
    logic              m_in_flight;
    logic              m_acked;
    logic              m_en;
    logic [DATA_W-1:0] m_data;
    logic              m_ovf;

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; clr_ovf = 1'b0;
        man_rdy = 1'b1; tx_model_on = 1'b0;
        #12;
        check("reset_tx_en", 32'(tx_en), 0);
        check("reset_count", 32'(count), 0);
        check("reset_empty", 32'(empty), 1);
        check("reset_full", 32'(full), 0);
        check("reset_ovf", 32'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single byte, simultaneous write+pop at count 3, and a WAIT_LO stall.
        add(1, 8'h2A, 1, 0, 1, 0, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 1, 8'h2A, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h2A, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h2A, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h2A, 0);
        add(1, 8'h11, 0, 0, 1, 0, 8'h2A, 0);
        add(1, 8'h22, 0, 0, 2, 0, 8'h2A, 0);
        add(1, 8'h33, 0, 0, 3, 0, 8'h2A, 0);
        add(1, 8'h44, 1, 0, 3, 1, 8'h11, 0);
        add(0, 8'h00, 0, 0, 3, 0, 8'h11, 0);
        add(0, 8'h00, 1, 0, 3, 0, 8'h11, 0);
        add(0, 8'h00, 1, 0, 2, 1, 8'h22, 0);
        add(0, 8'h00, 1, 0, 2, 0, 8'h22, 0);
        add(0, 8'h00, 1, 0, 2, 0, 8'h22, 0);
        add(0, 8'h00, 0, 0, 2, 0, 8'h22, 0);
        add(0, 8'h00, 1, 0, 2, 0, 8'h22, 0);
        add(0, 8'h00, 1, 0, 1, 1, 8'h33, 0);
        add(0, 8'h00, 0, 0, 1, 0, 8'h33, 0);
        add(0, 8'h00, 1, 0, 1, 0, 8'h33, 0);
        add(0, 8'h00, 1, 0, 0, 1, 8'h44, 0);
        add(0, 8'h00, 0, 0, 0, 0, 8'h44, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h44, 0);
        for (int i = 0; i < vq.size(); i++) begin
            wr_valid = vq[i].wr; wr_data = vq[i].d; man_rdy = vq[i].rdy; clr_ovf = vq[i].clr;
            tick();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vq[i].cnt));
            check($sformatf("vec%0d_tx_en", i), 32'(tx_en), 32'(vq[i].en));
            check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vq[i].txd));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vq[i].ovf));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vq[i].cnt == 0));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vq[i].cnt == DEPTH));
        end
        wr_valid = 1'b0; clr_ovf = 1'b0;

        // Fill with the transmitter stalled, then drop a byte on the edge of the first pop.
        man_rdy = 1'b0;
        got_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        check("fill_count", 32'(count), DEPTH);
        check("fill_full", 32'(full), 1);
        check("fill_ovf", 32'(overflow), 0);
        tx_model_on = 1'b1;
        wr_valid = 1'b1; wr_data = 8'h10;
        tick();
        wr_valid = 1'b0;
        check("drop_count", 32'(count), DEPTH - 1);
        check("drop_ovf", 32'(overflow), 1);
        check("drop_tx_en", 32'(tx_en), 1);
        check("drop_tx_data", 32'(tx_data), 0);
        for (int i = 0; i < 3000 && got_q.size() < DEPTH; i++) tick();
        repeat (60) tick();
        check("drain_bytes", 32'(got_q.size()), DEPTH);
        for (int i = 0; i < DEPTH && i < got_q.size(); i++)
            check($sformatf("drain_byte%0d", i), 32'(got_q[i]), 32'(i));
        check("drain_empty", 32'(empty), 1);
        check("drain_ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 0);

        // Randomized traffic with the behavioural transmitter.
        m_q.delete(); m_in_flight = 1'b0; m_acked = 1'b0; m_ovf = 1'b0; m_data = 8'h0F;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic rdy, pop, accept;
            @(negedge clk);
            #1;
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_data  = 8'($urandom);
            clr_ovf  = ($urandom_range(0, 7) == 0);
            rdy    = tx_rdy;
            pop    = !m_in_flight && (m_q.size() > 0) && rdy;
            accept = wr_valid && (m_q.size() < DEPTH);
            m_en   = pop;
            if (pop) begin
                m_data = m_q.pop_front();
                m_in_flight = 1'b1;
                m_acked = 1'b0;
            end else if (m_in_flight) begin
                if (!m_acked) m_acked = !rdy;
                else if (rdy) m_in_flight = 1'b0;
            end
            if (accept) m_q.push_back(wr_data);
            if (wr_valid && !accept) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            tick();
            check("rnd_count", 32'(count), 32'(m_q.size()));
            check("rnd_tx_en", 32'(tx_en), 32'(m_en));
            check("rnd_tx_data", 32'(tx_data), 32'(m_data));
            check("rnd_ovf", 32'(overflow), 32'(m_ovf));
            check("rnd_full", 32'(full), 32'(m_q.size() == DEPTH));
        end
        wr_valid = 1'b0; clr_ovf = 1'b0;

        // Asynchronous reset between clock edges, then the FIFO restarts cleanly.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx_en", 32'(tx_en), 0);
        check("async_rst_count", 32'(count), 0);
        check("async_rst_empty", 32'(empty), 1);
        check("async_rst_ovf", 32'(overflow), 0);
        check("async_rst_tx_data", 32'(tx_data), 0);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        @(negedge clk);
        wr_valid = 1'b1; wr_data = 8'h5A;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int i = 0; i < 200 && got_q.size() < 1; i++) tick();
        repeat (20) tick();
        check("post_rst_bytes", 32'(got_q.size()), 1);
        if (got_q.size() > 0) check("post_rst_byte", 32'(got_q[0]), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
